mem_initiator: RTL and testbench
================================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter TIMEOUT, default 1024, max WAIT cycles before a request is abandoned with error.
REQ-002 clock  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  initiator can accept a request.
REQ-006 req_instr  input  1  fetch-class access; forwarded to bram_instr.
REQ-007 req_wren  input  1  1=store, 0=load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_unsigned  input  1  zero-extend load result when 1, sign-extend when 0.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_error  output  1  qualifies rsp_valid: misaligned, illegal size or timeout.
REQ-015 bram_valid, bram_instr  output  1 each  memory request strobe and class.
REQ-016 bram_addr  output  32  word address, bits [1:0] always 0.
REQ-017 bram_wdata  output  32; bram_wstrb  output  4  lane-replicated data, byte enables.
REQ-018 bram_rdata  input  32; bram_ready  input  1  memory read data, one-cycle completion pulse.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT; req_ready=1 only in IDLE.
REQ-020 Accept on req_valid&req_ready; all request fields latched at acceptance.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: no bus access, rsp_valid=1 with rsp_error=1 next cycle, stay IDLE.
REQ-022 Legal accept -> ISSUE; ISSUE drives bram_valid=1 for exactly one cycle, then WAIT.
REQ-023 bram_valid SHALL be 0 in IDLE and WAIT; memory never sees two consecutive valid cycles for one request.
REQ-024 bram_addr/bram_wdata/bram_wstrb/bram_instr held stable from ISSUE through end of WAIT.
REQ-025 Store wstrb: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; loads 0000.
REQ-026 Store wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-027 WAIT with bram_ready=1: capture bram_rdata, extract lane (shift by 8*addr[1:0]), extend per size/req_unsigned, rsp_valid=1 next cycle with rsp_error=0, state IDLE.
REQ-028 Zero-wait memory latency: accept cycle N, bram_valid N+1, bram_ready N+2, rsp_valid N+3.
REQ-029 bram_ready in IDLE or ISSUE SHALL be ignored.
REQ-030 WAIT counter cleared on entry; TIMEOUT cycles without bram_ready -> rsp_valid=1, rsp_error=1, IDLE; a late bram_ready is then ignored.
REQ-031 A new request may be accepted in the same cycle rsp_valid is high.

Reset
REQ-032 reset forces IDLE, clears timeout counter and latched request; next cycle all outputs 0 except req_ready=1.
REQ-033 reset mid-transaction drops the request with no response.

Structure
REQ-034 Size encodings and state enum SHALL reside in package configure.
REQ-035 Lane extraction/extension SHALL be sub-module mem_align (combinational, used for load data).

Verification
REQ-036 Zero-wait memory: load word 0x100, mem=0xDEADBEEF -> bram_valid cycle 1, rsp_valid cycle 3, rdata 0xDEADBEEF.
REQ-037 Load byte signed 0x103, word 0x80FF0000 -> rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Store half 0xABCD to 0x202 -> wstrb 1100, wdata 0xABCDABCD, rsp_rdata 0.
REQ-039 Load word 0x101 -> rsp_error=1 one cycle later, bram_valid never asserted.
REQ-040 Memory with 3-cycle delay -> bram_valid high exactly one cycle, response 4 cycles after ready-less issue; TIMEOUT=4 with silent memory -> rsp_error=1 after 4 WAIT cycles.
REQ-041 reset asserted in WAIT -> no rsp_valid; subsequent load completes normally.

Source files
------------

// File: rtl/configure.sv
// rtl/configure.sv - shared size encodings, FSM states and alignment check for mem_initiator
package configure;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  // Requests that must be refused without touching the memory bus.
  function automatic logic req_rejected(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SIZE_HALF:    return ofs[0];
      SIZE_WORD:    return (ofs != 2'b00);
      SIZE_ILLEGAL: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - selects the addressed lane of a load word and sign/zero extends it
module mem_align
  import configure::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_data >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
      SIZE_HALF: o_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
      default:   o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - turns core load/store requests into single-beat word accesses on a BRAM-style bus
module mem_initiator
  import configure::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_instr,
  input  logic        req_wren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      r_state;
  state_e      w_next;
  logic        r_instr;
  logic        r_wren;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic        r_rsp_valid;
  logic        r_rsp_error;
  logic [31:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_reject;
  logic        w_done;
  logic        w_timeout;
  logic [31:0] w_load;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_reject  = req_rejected(req_size, req_addr[1:0]);
  assign w_done    = (r_state == ST_WAIT) && bram_ready;
  assign w_timeout = (r_state == ST_WAIT) && !bram_ready && (r_cnt == CW'(TIMEOUT - 1));

  mem_align u_align (
    .i_data     (bram_rdata),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_reject) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_done || w_timeout) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_instr     <= 1'b0;
      r_wren      <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_instr    <= req_instr;
        r_wren     <= req_wren;
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_rsp_valid <= (w_accept && w_reject) || w_done || w_timeout;
      r_rsp_error <= (w_accept && w_reject) || w_timeout;
      r_rsp_rdata <= (w_done && !r_wren) ? w_load : 32'h0;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_error  = r_rsp_error;
  assign rsp_rdata  = r_rsp_rdata;
  assign bram_valid = (r_state == ST_ISSUE);
  assign bram_instr = r_instr;
  assign bram_addr  = {r_addr[31:2], 2'b00};

  // Store data and strobes come straight from the latched request, so they stay put until the next accept.
  always_comb begin
    bram_wdata = r_wdata;
    bram_wstrb = 4'b0000;
    case (r_size)
      SIZE_BYTE: begin
        bram_wdata = {4{r_wdata[7:0]}};
        bram_wstrb = 4'b0001 << r_addr[1:0];
      end
      SIZE_HALF: begin
        bram_wdata = {2{r_wdata[15:0]}};
        bram_wstrb = 4'b0011 << {r_addr[1], 1'b0};
      end
      SIZE_WORD: bram_wstrb = 4'b1111;
      default:   bram_wstrb = 4'b0000;
    endcase
    if (!r_wren) bram_wstrb = 4'b0000;
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed self-checking bench for mem_initiator (TIMEOUT=4)
module tb_mem_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_instr;
  logic        req_wren;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        bram_valid;
  logic        bram_instr;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_wstrb;
  logic [31:0] bram_rdata;
  logic        bram_ready;

  int n_checks = 0;
  int n_errors = 0;

  int          r_lat;
  int          r_vcyc;
  int          r_vcnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_baddr;
  logic [31:0] r_bwdata;
  logic [3:0]  r_bwstrb;
  logic        r_binstr;

  mem_initiator #(.TIMEOUT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_instr    (req_instr),
    .req_wren     (req_wren),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .bram_valid   (bram_valid),
    .bram_instr   (bram_instr),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata),
    .bram_wstrb   (bram_wstrb),
    .bram_rdata   (bram_rdata),
    .bram_ready   (bram_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // gap = cycles from bram_valid to bram_ready (1 = zero-wait memory), 0 = memory never answers.
  task automatic do_req(input logic instr, input logic wren, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input int gap, input logic [31:0] mem);
    r_lat = -1; r_vcyc = 0; r_vcnt = 0; r_err = 1'bx; r_rdata = 32'hx;
    bram_rdata   = mem;
    req_valid    = 1'b1;
    req_instr    = instr;
    req_wren     = wren;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (bram_valid) begin
        r_vcnt++;
        r_vcyc   = c;
        r_baddr  = bram_addr;
        r_bwdata = bram_wdata;
        r_bwstrb = bram_wstrb;
        r_binstr = bram_instr;
      end
      if (rsp_valid) begin
        r_lat   = c;
        r_err   = rsp_error;
        r_rdata = rsp_rdata;
        break;
      end
      bram_ready = (gap > 0) && (r_vcyc > 0) && (c == r_vcyc + gap);
      step();
    end
    bram_ready = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int lat, input logic err,
                            input logic [31:0] rdata, input int vcnt);
    check({tag, "_lat"}, r_lat, lat);
    check({tag, "_err"}, r_err, err);
    check({tag, "_rdata"}, r_rdata, rdata);
    check({tag, "_vcnt"}, r_vcnt, vcnt);
    step();
    check({tag, "_pulse"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int n_rsp;
    reset = 1'b1; req_valid = 1'b0; req_instr = 1'b0; req_wren = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
    bram_rdata = 32'h0; bram_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_bram_valid", bram_valid, 1'b0);
    check("rst_bram_instr", bram_instr, 1'b0);
    check("rst_bram_addr", bram_addr, 32'h0);
    check("rst_bram_wdata", bram_wdata, 32'h0);
    check("rst_bram_wstrb", bram_wstrb, 4'h0);

    check("lw_ready", req_ready, 1'b1);
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, 32'hDEADBEEF);
    check("lw_vcyc", r_vcyc, 1);
    check("lw_addr", r_baddr, 32'h100);
    check("lw_wstrb", r_bwstrb, 4'h0);
    expect_rsp("lw", 3, 1'b0, 32'hDEADBEEF, 1);

    do_req(1'b0, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1, 32'h80FF0000);
    check("lbs_addr", r_baddr, 32'h100);
    expect_rsp("lbs", 3, 1'b0, 32'hFFFFFF80, 1);
    do_req(1'b0, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1, 32'h80FF0000);
    expect_rsp("lbu", 3, 1'b0, 32'h00000080, 1);

    do_req(1'b0, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 1, 32'h8001BEEF);
    expect_rsp("lhs", 3, 1'b0, 32'hFFFF8001, 1);
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 1'b1, 1, 32'h1234F00D);
    check("lhu_instr", r_binstr, 1'b1);
    expect_rsp("lhu", 3, 1'b0, 32'h0000F00D, 1);

    do_req(1'b0, 1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 1, 32'h12345678);
    check("sh_addr", r_baddr, 32'h200);
    check("sh_wstrb", r_bwstrb, 4'b1100);
    check("sh_wdata", r_bwdata, 32'hABCDABCD);
    check("sh_instr", r_binstr, 1'b0);
    expect_rsp("sh", 3, 1'b0, 32'h0, 1);

    do_req(1'b0, 1'b1, 32'h301, 32'hFFFFFF5A, 2'b00, 1'b0, 1, 32'h0);
    check("sb_wstrb", r_bwstrb, 4'b0010);
    check("sb_wdata", r_bwdata, 32'h5A5A5A5A);
    expect_rsp("sb", 3, 1'b0, 32'h0, 1);

    do_req(1'b0, 1'b1, 32'h400, 32'h11223344, 2'b10, 1'b0, 1, 32'h0);
    check("sw_wstrb", r_bwstrb, 4'b1111);
    check("sw_wdata", r_bwdata, 32'h11223344);
    expect_rsp("sw", 3, 1'b0, 32'h0, 1);

    do_req(1'b0, 1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 1, 32'hCAFEF00D);
    expect_rsp("lw_mis", 1, 1'b1, 32'h0, 0);
    do_req(1'b0, 1'b0, 32'h103, 32'h0, 2'b01, 1'b0, 1, 32'hCAFEF00D);
    expect_rsp("lh_mis", 1, 1'b1, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'h100, 32'h0, 2'b11, 1'b0, 1, 32'hCAFEF00D);
    expect_rsp("size11", 1, 1'b1, 32'h0, 0);

    do_req(1'b0, 1'b0, 32'h500, 32'h0, 2'b10, 1'b0, 3, 32'h0BADC0DE);
    check("slow_vcyc", r_vcyc, 1);
    expect_rsp("slow", 5, 1'b0, 32'h0BADC0DE, 1);

    do_req(1'b0, 1'b0, 32'h600, 32'h0, 2'b10, 1'b0, 0, 32'h55555555);
    expect_rsp("tmo", 6, 1'b1, 32'h0, 1);
    bram_ready = 1'b1;
    step();
    bram_ready = 1'b0;
    check("late_rdy_rsp", rsp_valid, 1'b0);
    check("late_rdy_bvalid", bram_valid, 1'b0);

    req_valid = 1'b1; req_wren = 1'b0; req_addr = 32'h700; req_size = 2'b10;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_ready", req_ready, 1'b1);
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) n_rsp++;
      step();
    end
    check("midrst_no_rsp", n_rsp, 0);
    do_req(1'b0, 1'b0, 32'h704, 32'h0, 2'b10, 1'b0, 1, 32'h600DF00D);
    expect_rsp("post_rst", 3, 1'b0, 32'h600DF00D, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
